card_brush_sequencer: RTL and testbench
=======================================

// Module: card_brush_sequencer
// PURPOSE
//  Synthesizable replacement for the behavioural card feed that drives the es24 counter.
//  Holds one 12-row x COLS-column card image and scans it past two brush stations.
//  Per station it emits the 16-slot index-pulse set (9..0, 11, 12, 13..15) and the matching row on the column bus.
//  Its outputs feed es24 timing/digit inputs and the brush-1/brush-2 control gating directly.
// PARAMETERS
//  COLS      80  columns per card / width of the column bus
//  DIV_LOG2  6   inclk cycles per card point = DIV = 2**DIV_LOG2; minimum 1
// PORTS
//  inclk      in   1     clock
//  reset      in   1     synchronous reset, active low
//  load_we    in   1     write load_data into row load_row
//  load_row   in   4     row index: 0..9 = digit rows, 10 = row 11, 11 = row 12
//  load_data  in   COLS  row image; bit c = column c punched
//  load_go    in   1     start scanning the stored card
//  ready      out  1     idle; writes and load_go accepted
//  brush      out  1     0 = station 1 active/idle, 1 = station 2 active
//  pulses     out  16    index pulses, one-hot or zero
//  columns    out  COLS  row under the active brush, else 0
//  card_done  out  1     one-cycle strobe after the station-2 scan ends
// BEHAVIOUR
//  - Reset (reset==0 at a posedge inclk):
//    - state=IDLE, prescaler=0, slot=0, all 12 rows cleared.
//    - Outputs: ready=1, brush=0, pulses=0, columns=0, card_done=0.
//    - Reset wins over every other input, including mid-scan; the scan is abandoned.
//  - FSM: IDLE -> BR1 -> BR2 -> DONE -> IDLE.
//  - IDLE:
//    - load_we writes the row when load_row<=11; load_row>11 is ignored.
//    - load_go moves to BR1 with prescaler=0, slot=0.
//    - load_we and load_go in the same cycle: the write lands first and is part of the scanned card.
//  - Writes and load_go outside IDLE are ignored and have no side effects.
//  - BR1/BR2 timing:
//    - prescaler counts 0..DIV-1 and wraps.
//    - On wrap, slot increments 0..15.
//    - On wrap at slot 15: BR1 goes to BR2 (slot=0), BR2 goes to DONE.
//  - Slot -> pulse/row mapping:
//    - slots 1..10: pulses[9..0], rows 9..0
//    - slot 11: pulses[11], row 10
//    - slot 12: pulses[12], row 11
//    - slots 13..15: pulses[13..15], columns=0
//    - slot 0: no pulse, columns=0
//    - pulses[10] is always 0.
//  - Pulse bit high only while prescaler >= DIV/2, i.e. the second half of the slot; with DIV_LOG2=0 it is high for the whole slot.
//  - columns are stable for the whole slot and change only on slot boundaries.
//  - brush=1 exactly in BR2; 0 in IDLE, BR1 and DONE.
//  - DONE lasts one cycle: card_done=1, ready=0. Next cycle: IDLE, ready=1.
//  - Latency, with load_go sampled at edge T:
//    - BR1 slot 0 in cycle T+1.
//    - BR2 begins at T+1+16*DIV.
//    - card_done at T+1+32*DIV.
//    - ready at T+2+32*DIV.
//  - Registered outputs: all outputs are derived from registered state only; no combinational path from inputs.
//  - Card memory persists after DONE; load_go alone rescans the same card.
//  - Counters are sized so no state wraps: 4-bit slot, DIV_LOG2-bit prescaler.
// TESTING (DIV_LOG2=2, COLS=80)
//  1. Reset mid-BR2 -> next cycle: ready=1, brush=0, pulses=0, columns=0; a rescan gives all-zero columns.
//  2. Write row 3 = column 20 only, then load_go at T:
//     - pulses[3] high during cycles T+1+7*4+2 .. T+1+7*4+3 in BR1, same offsets +64 in BR2.
//     - columns[20]=1 for the full slot 7 each pass.
//     - card_done at T+129.
//  3. Write row 11 (card row 12) all ones:
//     - pulses[12] slot shows columns all 1.
//     - pulses[10] never asserts.
//     - slots 0 and 13..15 show columns=0.
//  4. load_we (row 0 = column 5) and load_go in the same cycle -> column 5 seen in slot 10 of both brushes.
//  5. Mid-scan:
//     - load_we row 0 and load_go -> ignored; the scan is unchanged and the memory is unchanged on rescan.
//     - load_row=13 in IDLE -> no row modified.
//  6. Back-to-back: load_go asserted again in the cycle ready rises -> second scan starts with identical timing; card_done strobes are 130 cycles apart.

Source files
------------

// File: rtl/card_brush_if.sv
// Card-feed handshake bundle: card load port toward the sequencer, brush/index/column
// outputs toward the es24 counter.
interface card_brush_if #(
  parameter int unsigned COLS = 80
) ();
  logic            load_we;
  logic [3:0]      load_row;
  logic [COLS-1:0] load_data;
  logic            load_go;
  logic            ready;
  logic            brush;
  logic [15:0]     pulses;
  logic [COLS-1:0] columns;
  logic            card_done;

  modport master (
    output load_we, load_row, load_data, load_go,
    input  ready, brush, pulses, columns, card_done
  );

  modport slave (
    input  load_we, load_row, load_data, load_go,
    output ready, brush, pulses, columns, card_done
  );
endinterface

// File: rtl/card_brush_sequencer.sv
// Holds one 12-row card image and scans it past brush stations 1 and 2, emitting the
// 16-slot index-pulse set and the row under the active brush.
module card_brush_sequencer #(
  parameter int unsigned COLS     = 80,
  parameter int unsigned DIV_LOG2 = 6
) (
  input logic         inclk,
  input logic         reset,
  card_brush_if.slave bus
);

  localparam int unsigned Div = 1 << DIV_LOG2;
  localparam int unsigned PW  = (DIV_LOG2 > 0) ? DIV_LOG2 : 1;
  localparam logic [PW-1:0] PreMax  = PW'(Div - 1);
  localparam logic [PW-1:0] PreHalf = PW'(Div / 2);

  typedef enum logic [1:0] {StIdle, StBr1, StBr2, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [3:0]      slot_q, slot_d;
  logic [COLS-1:0] rows_q [0:11];

  logic            ready_q, brush_q, done_q;
  logic [15:0]     pulses_q, pulse_d;
  logic [COLS-1:0] columns_q, col_d;

  logic            wrap;
  logic            has_pulse, has_row;
  logic [3:0]      pidx, row_idx;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    slot_d  = slot_q;
    wrap    = (pre_q == PreMax);
    unique case (state_q)
      StIdle: begin
        if (bus.load_go) begin
          state_d = StBr1;
          pre_d   = '0;
          slot_d  = '0;
        end
      end
      StBr1, StBr2: begin
        pre_d = wrap ? '0 : pre_q + 1'b1;
        if (wrap) begin
          slot_d = slot_q + 4'd1;
          if (slot_q == 4'd15) state_d = (state_q == StBr1) ? StBr2 : StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next state so the registered copies line up with the state.
  always_comb begin
    pulse_d   = '0;
    col_d     = '0;
    has_pulse = 1'b0;
    has_row   = 1'b0;
    pidx      = '0;
    row_idx   = '0;
    if (state_d == StBr1 || state_d == StBr2) begin
      if (slot_d >= 4'd1 && slot_d <= 4'd10) begin
        has_pulse = 1'b1;
        has_row   = 1'b1;
        pidx      = 4'd10 - slot_d;
        row_idx   = 4'd10 - slot_d;
      end else if (slot_d == 4'd11) begin
        has_pulse = 1'b1;
        has_row   = 1'b1;
        pidx      = 4'd11;
        row_idx   = 4'd10;
      end else if (slot_d == 4'd12) begin
        has_pulse = 1'b1;
        has_row   = 1'b1;
        pidx      = 4'd12;
        row_idx   = 4'd11;
      end else if (slot_d >= 4'd13) begin
        has_pulse = 1'b1;
        pidx      = slot_d;
      end
      if (has_pulse) pulse_d[pidx] = (pre_d >= PreHalf);
      if (has_row) col_d = rows_q[row_idx];
    end
  end

  always_ff @(posedge inclk) begin
    if (!reset) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      slot_q    <= '0;
      for (int i = 0; i < 12; i++) rows_q[i] <= '0;
      ready_q   <= 1'b1;
      brush_q   <= 1'b0;
      done_q    <= 1'b0;
      pulses_q  <= '0;
      columns_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      slot_q    <= slot_d;
      if (state_q == StIdle && bus.load_we && bus.load_row <= 4'd11) begin
        rows_q[bus.load_row] <= bus.load_data;
      end
      ready_q   <= (state_d == StIdle);
      brush_q   <= (state_d == StBr2);
      done_q    <= (state_d == StDone);
      pulses_q  <= pulse_d;
      columns_q <= col_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.brush     = brush_q;
  assign bus.pulses    = pulses_q;
  assign bus.columns   = columns_q;
  assign bus.card_done = done_q;

endmodule

// File: tb/tb_card_brush_sequencer.sv
// Scoreboard bench for card_brush_sequencer (COLS=80, DIV_LOG2=2): every driven scan pushes
// its per-cycle expected outputs, a negedge monitor pops and compares them.
module tb_card_brush_sequencer;

  localparam int COLS = 80;
  localparam int DIV  = 4;

  typedef struct packed {
    logic            ready;
    logic            brush;
    logic [15:0]     pulses;
    logic [COLS-1:0] columns;
    logic            done;
  } rec_t;

  typedef struct {
    rec_t  v;
    string tag;
    int    idx;
  } exp_t;

  logic inclk = 1'b0;
  logic reset = 1'b0;
  card_brush_if #(.COLS(COLS)) bus ();

  card_brush_sequencer #(.COLS(COLS), .DIV_LOG2(2)) dut (
    .inclk(inclk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 inclk = ~inclk;

  exp_t            exp_q[$];
  int              done_cyc[$];
  logic [COLS-1:0] mem [0:11];
  int              checks   = 0;
  int              failures = 0;
  int              cyc      = 0;

  always @(posedge inclk) cyc <= cyc + 1;

  always @(negedge inclk) begin
    rec_t obs;
    exp_t e;
    if (bus.card_done) done_cyc.push_back(cyc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      obs.ready   = bus.ready;
      obs.brush   = bus.brush;
      obs.pulses  = bus.pulses;
      obs.columns = bus.columns;
      obs.done    = bus.card_done;
      checks++;
      assert (obs === e.v) else begin
        failures++;
        $error("FAIL %s[%0d] observed=%h expected=%h", e.tag, e.idx, obs, e.v);
      end
    end
  end

  function automatic rec_t idle_rec();
    rec_t r;
    r       = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic rec_t scan_rec(int s, int p);
    rec_t r;
    int   slot;
    int   b;
    int   row;
    r     = '0;
    slot  = s % 16;
    b     = -1;
    row   = -1;
    r.brush = (s >= 16);
    if (slot >= 1 && slot <= 10) begin
      b   = 10 - slot;
      row = 10 - slot;
    end else if (slot == 11) begin
      b   = 11;
      row = 10;
    end else if (slot == 12) begin
      b   = 12;
      row = 11;
    end else if (slot >= 13) begin
      b = slot;
    end
    if (b >= 0 && p >= DIV / 2) r.pulses[b] = 1'b1;
    if (row >= 0) r.columns = mem[row];
    return r;
  endfunction

  task automatic push(input string tag, input int idx, input rec_t v);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic push_scan(input string tag);
    rec_t d;
    for (int s = 0; s < 32; s++) begin
      for (int p = 0; p < DIV; p++) push(tag, s * DIV + p, scan_rec(s, p));
    end
    d      = '0;
    d.done = 1'b1;
    push(tag, 32 * DIV, d);
    push(tag, 32 * DIV + 1, idle_rec());
  endtask

  task automatic wr(input logic [3:0] row, input logic [COLS-1:0] data, input string tag);
    @(negedge inclk);
    #1;
    bus.load_we   = 1'b1;
    bus.load_row  = row;
    bus.load_data = data;
    if (row <= 4'd11) mem[row] = data;
    push(tag, 0, idle_rec());
    @(posedge inclk);
    #1;
    bus.load_we = 1'b0;
  endtask

  task automatic go(input string tag, input logic with_wr, input logic [3:0] row,
                    input logic [COLS-1:0] data);
    @(negedge inclk);
    #1;
    bus.load_go = 1'b1;
    if (with_wr) begin
      bus.load_we   = 1'b1;
      bus.load_row  = row;
      bus.load_data = data;
      if (row <= 4'd11) mem[row] = data;
    end
    push_scan(tag);
    @(posedge inclk);
    #1;
    bus.load_go = 1'b0;
    bus.load_we = 1'b0;
  endtask

  task automatic wait_q(input int n, input string tag);
    int b;
    b = 0;
    while (exp_q.size() > n && b < 400) begin
      @(posedge inclk);
      b++;
    end
    if (exp_q.size() > n) begin
      checks++;
      failures++;
      $error("FAIL timeout_%s observed=%0d pending expected<=%0d", tag, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  initial begin
    int gap;
    logic [COLS-1:0] one;
    bus.load_we   = 1'b0;
    bus.load_row  = '0;
    bus.load_data = '0;
    bus.load_go   = 1'b0;
    for (int i = 0; i < 12; i++) mem[i] = '0;
    push("reset", 0, idle_rec());
    @(posedge inclk);
    #1;
    reset = 1'b1;
    wait_q(0, "reset");

    // Single punch in row 3, column 20.
    one = '0;
    one[20] = 1'b1;
    wr(4'd3, one, "wr_row3");
    go("row3_scan", 1'b0, '0, '0);
    wait_q(0, "row3_scan");

    // Card row 12 fully punched.
    wr(4'd11, '1, "wr_row12");
    go("row12_scan", 1'b0, '0, '0);
    wait_q(0, "row12_scan");

    // Write and start in the same cycle.
    one = '0;
    one[5] = 1'b1;
    go("same_cycle", 1'b1, 4'd0, one);
    wait_q(0, "same_cycle");

    // Writes and load_go during a scan are ignored.
    go("midscan", 1'b0, '0, '0);
    wait_q(60, "midscan_part");
    @(posedge inclk);
    #1;
    bus.load_we   = 1'b1;
    bus.load_row  = 4'd0;
    bus.load_data = '1;
    bus.load_go   = 1'b1;
    @(posedge inclk);
    #1;
    bus.load_we = 1'b0;
    bus.load_go = 1'b0;
    wait_q(0, "midscan");
    wr(4'd13, '1, "wr_row13");
    go("rescan", 1'b0, '0, '0);
    wait_q(0, "rescan");

    // Back-to-back scans: second load_go in the cycle ready rises.
    done_cyc.delete();
    go("b2b_a", 1'b0, '0, '0);
    wait_q(1, "b2b_a");
    go("b2b_b", 1'b0, '0, '0);
    wait_q(0, "b2b_b");
    gap = (done_cyc.size() >= 2) ? done_cyc[done_cyc.size() - 1] - done_cyc[done_cyc.size() - 2]
                                 : -1;
    checks++;
    assert (gap == 130) else begin
      failures++;
      $error("FAIL done_gap observed=%0d expected=130", gap);
    end

    // Reset in the middle of BR2 abandons the scan and clears the card.
    go("pre_reset", 1'b0, '0, '0);
    wait_q(40, "pre_reset");
    @(negedge inclk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) mem[i] = '0;
    push("midreset", 0, idle_rec());
    @(posedge inclk);
    #1;
    reset = 1'b1;
    wait_q(0, "midreset");
    go("zero_scan", 1'b0, '0, '0);
    wait_q(0, "zero_scan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
